lc_dco_fcal: RTL and testbench
==============================

// Module: lc_dco_fcal
// PURPOSE
//  Digital frequency-calibration controller driving the 8-bit switched-cap bank of the LC DCO.
//  All swcap cells are equal-weight, so the tuning code is thermometer: k = number of sw bits set.
//  More caps means lower frequency.
//  Binary-searches k: counts divided-DCO edges over a reference window and compares to target_cnt.
//  Result: largest k with count >= target. Also provides a manual override.
// PARAMETERS
//  SW_W        8     number of swcap cells (sw width); k range 0..SW_W
//  CNT_W       12    edge-counter / target width, saturating
//  WIN_CYC     1024  measurement window, clk cycles
//  SETTLE_CYC  64    wait after every code change before measuring
//  TRACK_HYST  2     tracking hysteresis in counts (used only with LC_DCO_FCAL_TRACK_EN)
//  localparam KW = $clog2(SW_W+1); localparam ITER = $clog2(SW_W+1) (4 for SW_W=8)
// PORTS
//  clk         in   1      reference clock
//  resetn      in   1      asynchronous active-low reset
//  start       in   1      one-cycle pulse: begin calibration
//  manual_en   in   1      1: sw driven from manual_k, FSM held in IDLE
//  manual_k    in   KW     manual code; values > SW_W clamp to SW_W
//  target_cnt  in   CNT_W  required edge count per window
//  dco_edge    in   1      one-cycle pulse per divided-DCO period, already synchronized to clk
//  sw          out  SW_W   thermometer cap control to DCO: sw[i] = (i < k)
//  k_out       out  KW     current code
//  meas_cnt    out  CNT_W  count from the last completed window
//  busy        out  1      calibration in progress
//  done        out  1      level; high from search end until next start, manual_en or reset
//  err         out  1      valid with done; every window failed, so target is above all tested codes
// BEHAVIOUR
//  Reset values: k=0 (sw=0), meas_cnt=0, busy=0, done=0, err=0, state IDLE.
//  FSM states: IDLE -> SETTLE -> MEASURE -> DECIDE -> (SETTLE | DONE).
//  IDLE: start sampled high sets lo=0, hi=SW_W, k=mid=(lo+hi+1)>>1, busy=1, then goes to SETTLE.
//  SETTLE: waits SETTLE_CYC cycles, then goes to MEASURE.
//  MEASURE: exactly WIN_CYC cycles. Each dco_edge increments cnt, saturating at 2^CNT_W-1.
//    At window end, meas_cnt latches cnt.
//  DECIDE (1 cycle):
//    if meas_cnt >= target_cnt then lo=mid, else hi=mid-1.
//    If lo<hi: k=new mid, go to SETTLE.
//    Otherwise: k=lo, busy=0, done=1, go to DONE.
//  Iteration cost is SETTLE_CYC+WIN_CYC+1 cycles. done rises exactly 1+ITER*(SETTLE_CYC+WIN_CYC+1)
//    cycles after start is sampled.
//  Search always runs ITER iterations: lo==hi may occur earlier, in which case remaining iterations
//    re-measure k=lo and do not change it.
//  err=1 at done iff result k=0 and no window passed.
//  start while busy: ignored. start in DONE: clears done/err and restarts the search.
//  manual_en=1, any state: aborts the search next cycle. FSM goes to IDLE, busy=done=err=0,
//    k=min(manual_k,SW_W). meas_cnt holds.
//  manual_en falling: k holds; FSM stays IDLE until start.
//  dco_edge outside MEASURE is ignored. The comparison is unsigned, and target_cnt=0 always passes.
//  Asynchronous reset mid-search returns every output to its reset value immediately.
// CONFIGURATION
//  LC_DCO_FCAL_TRACK_EN defined:
//    DONE loops continuously SETTLE -> MEASURE -> DECIDE, with done and err held and busy=0.
//    In tracking DECIDE:
//      meas_cnt < target_cnt and k<SW_W: k-=1 ... no: k>0 means fewer caps, so k-=1.
//      meas_cnt >= target_cnt+TRACK_HYST (evaluated in CNT_W+1 bits) and k<SW_W: k+=1.
//    Each step is at most 1 code per window. Rule restated plainly:
//      below target -> remove a cap (k-1, if k>0); at or above target+TRACK_HYST -> add a cap (k+1, if k<SW_W).
//  LC_DCO_FCAL_TRACK_EN not defined: DONE is a static hold state and TRACK_HYST is unused.
// STRUCTURE
//  Package lc_dco_fcal_pkg holds:
//    state enum (IDLE, SETTLE, MEASURE, DECIDE, DONE)
//    function therm(k) returning an SW_W-bit thermometer code
//    function clamp_k
//  Sub-module lc_dco_fcal_meas: window timer plus saturating edge counter.
//    Inputs: go pulse, dco_edge. Outputs: cnt, valid pulse.
//    Reused for the SETTLE wait with edge counting disabled.
// TESTING
//  Defaults, DCO model with edges/window = 900 - 40*k, target_cnt=700
//    -> done after 4*(64+1024+1)+1 cycles, k_out=5, sw=8'h1F, err=0.
//  target_cnt=1000 (unreachable) -> k_out=0, sw=8'h00, err=1.
//  target_cnt=0 -> k_out=8, sw=8'hFF.
//  Edge every cycle with CNT_W=8 -> meas_cnt saturates at 255, with no wrap.
//  manual_en=1 during the 2nd MEASURE with manual_k=12
//    -> next cycle: busy=0, k_out=8, sw=8'hFF. A later start runs a full search.
//  resetn low mid-SETTLE -> sw=0, busy=0, done=0 asynchronously.
//  Extra check with LC_DCO_FCAL_TRACK_EN: after lock at k=5, change the model to 900-40*k+80
//    -> k steps 6, then 7, one window apart. With the model at target+1, k holds (hysteresis).
//  start pulsed while busy -> no restart; done timing is unchanged.

Source files
------------

// File: rtl/lc_dco_fcal_pkg.sv
// Shared types and helpers for the LC DCO frequency-calibration controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lc_dco_fcal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_DECIDE,
        ST_DONE
    } state_t;

    // Upper bound on the swcap bank width the helpers can express.
    localparam int THERM_MAX_W = 32;

    // Thermometer code: bit i set when i < k.
    function automatic logic [THERM_MAX_W-1:0] therm(input int k);
        logic [THERM_MAX_W-1:0] t;
        for (int i = 0; i < THERM_MAX_W; i++) begin
            t[i] = (i < k);
        end
        return t;
    endfunction

    // Limit a requested code to the number of physical cells.
    function automatic int clamp_k(input int k, input int k_max);
        return (k > k_max) ? k_max : k;
    endfunction

endpackage

// File: rtl/lc_dco_fcal_meas.sv
// Window timer plus saturating edge counter, shared by the SETTLE wait and the MEASURE window.
// Latency: o_valid is high in the last cycle of an i_len-cycle phase started by i_go; o_cnt includes that cycle.
// Backpressure: none; a new i_go restarts the timer and clears the count at any time.
//
// Ports: clk/resetn (async active-low), i_go (phase start pulse, first cycle of the phase),
//        i_len (phase length, >= 2), i_cnt_en (count edges this cycle), i_edge (dco edge pulse),
//        o_cnt (count including the current cycle), o_valid (last cycle of the phase).
module lc_dco_fcal_meas #(
    parameter int CNT_W = 12,
    parameter int TMR_W = 11
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_go,
    input  logic [TMR_W-1:0] i_len,
    input  logic             i_cnt_en,
    input  logic             i_edge,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_valid
);

    logic [TMR_W-1:0] r_left;
    logic             r_run;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_base;
    logic             w_inc;

    // The go cycle is the first counted cycle, so the count restarts from zero combinationally.
    assign w_base  = i_go ? '0 : r_cnt;
    assign w_inc   = i_cnt_en && i_edge && (w_base != '1);
    assign o_cnt   = w_base + {{(CNT_W-1){1'b0}}, w_inc};
    assign o_valid = r_run && !i_go && (r_left == TMR_W'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_left <= '0;
            r_run  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_cnt <= o_cnt;
            if (i_go) begin
                r_left <= i_len - TMR_W'(1);
                r_run  <= 1'b1;
            end else if (r_run) begin
                r_left <= r_left - TMR_W'(1);
                r_run  <= (r_left != TMR_W'(1));
            end
        end
    end

endmodule

// File: rtl/lc_dco_fcal.sv
// Frequency calibration of the LC DCO swcap bank: binary search of the thermometer code k against an edge-count target.
// Latency: done rises 1+ITER*(SETTLE_CYC+WIN_CYC+1) cycles after start; manual_en takes effect the next cycle.
// Backpressure: start is ignored while busy; manual_en overrides everything.
//
// Ports: clk, resetn (async active-low), start, manual_en, manual_k[KW], target_cnt[CNT_W], dco_edge,
//        sw[SW_W], k_out[KW], meas_cnt[CNT_W], busy, done, err.
// Option: define LC_DCO_FCAL_TRACK_EN to keep adjusting k by +/-1 per window after lock.
module lc_dco_fcal
    import lc_dco_fcal_pkg::*;
#(
    parameter int  SW_W       = 8,
    parameter int  CNT_W      = 12,
    parameter int  WIN_CYC    = 1024,
    parameter int  SETTLE_CYC = 64,
    parameter int  TRACK_HYST = 2,
    localparam int KW         = $clog2(SW_W + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             manual_en,
    input  logic [KW-1:0]    manual_k,
    input  logic [CNT_W-1:0] target_cnt,
    input  logic             dco_edge,
    output logic [SW_W-1:0]  sw,
    output logic [KW-1:0]    k_out,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int ITER  = $clog2(SW_W + 1);
    localparam int IW    = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int TMR_W = $clog2(((WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC) + 1);
    localparam logic [KW-1:0] MID0 = KW'((SW_W + 1) / 2);

    if (SW_W < 1 || SW_W > THERM_MAX_W || WIN_CYC < 2 || SETTLE_CYC < 2 || TRACK_HYST < 0) begin : g_bad_param
        $error("lc_dco_fcal: parameter out of range");
    end

    state_t           r_state;
    logic [KW-1:0]    r_k;
    logic [KW-1:0]    r_lo;
    logic [KW-1:0]    r_hi;
    logic [IW-1:0]    r_iter;
    logic [CNT_W-1:0] r_meas_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_pass;   // some window of this search met the target
    logic             r_go;
    logic             r_track;  // current loop is post-lock tracking, not search

    logic [CNT_W-1:0] w_cnt;
    logic             w_valid;
    logic             w_cnt_en;
    logic [TMR_W-1:0] w_len;
    logic             w_pass;
    logic             w_last;
    logic             w_start_ok;
    logic [KW-1:0]    w_lo_n;
    logic [KW-1:0]    w_hi_n;
    logic [KW:0]      w_sum;

    assign w_cnt_en   = (r_state == ST_MEASURE);
    assign w_len      = w_cnt_en ? TMR_W'(WIN_CYC) : TMR_W'(SETTLE_CYC);
    assign w_pass     = (r_meas_cnt >= target_cnt);
    assign w_last     = (r_iter == IW'(ITER - 1));
    assign w_start_ok = (r_state == ST_IDLE) || r_done;

    // Once lo==hi the range is frozen, so spare iterations only re-measure it.
    always_comb begin
        w_lo_n = r_lo;
        w_hi_n = r_hi;
        if (r_lo < r_hi) begin
            if (w_pass) w_lo_n = r_k;
            else        w_hi_n = r_k - KW'(1);
        end
        w_sum = {1'b0, w_lo_n} + {1'b0, w_hi_n} + {{KW{1'b0}}, 1'b1};
    end

`ifdef LC_DCO_FCAL_TRACK_EN
    logic [CNT_W:0] w_up_thr;
    assign w_up_thr = {1'b0, target_cnt} + (CNT_W + 1)'(TRACK_HYST);
`endif

    lc_dco_fcal_meas #(
        .CNT_W (CNT_W),
        .TMR_W (TMR_W)
    ) u_meas (
        .clk      (clk),
        .resetn   (resetn),
        .i_go     (r_go),
        .i_len    (w_len),
        .i_cnt_en (w_cnt_en),
        .i_edge   (dco_edge),
        .o_cnt    (w_cnt),
        .o_valid  (w_valid)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_lo       <= '0;
            r_hi       <= '0;
            r_iter     <= '0;
            r_meas_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_pass     <= 1'b0;
            r_go       <= 1'b0;
            r_track    <= 1'b0;
        end else begin
            r_go <= 1'b0;
            if (manual_en) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
                r_track <= 1'b0;
                r_k     <= KW'(clamp_k(int'(manual_k), SW_W));
            end else if (start && w_start_ok) begin
                r_state <= ST_SETTLE;
                r_go    <= 1'b1;
                r_lo    <= '0;
                r_hi    <= KW'(SW_W);
                r_k     <= MID0;
                r_iter  <= '0;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
                r_pass  <= 1'b0;
                r_track <= 1'b0;
            end else begin
                case (r_state)
                    ST_SETTLE: begin
                        if (w_valid) begin
                            r_state <= ST_MEASURE;
                            r_go    <= 1'b1;
                        end
                    end
                    ST_MEASURE: begin
                        if (w_valid) begin
                            r_state    <= ST_DECIDE;
                            r_meas_cnt <= w_cnt;
                        end
                    end
                    ST_DECIDE: begin
                        if (r_track) begin
`ifdef LC_DCO_FCAL_TRACK_EN
                            // Fewer caps raise the frequency; step at most one code per window.
                            if (r_meas_cnt < target_cnt) begin
                                if (r_k != '0) r_k <= r_k - KW'(1);
                            end else if ({1'b0, r_meas_cnt} >= w_up_thr) begin
                                if (r_k < KW'(SW_W)) r_k <= r_k + KW'(1);
                            end
`endif
                            r_state <= ST_DONE;
                        end else begin
                            r_lo   <= w_lo_n;
                            r_hi   <= w_hi_n;
                            r_pass <= r_pass || w_pass;
                            if (w_last) begin
                                r_k     <= w_lo_n;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_err   <= (w_lo_n == '0) && !(r_pass || w_pass);
                                r_state <= ST_DONE;
                            end else begin
                                r_k     <= w_sum[KW:1];
                                r_iter  <= r_iter + IW'(1);
                                r_state <= ST_SETTLE;
                                r_go    <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
`ifdef LC_DCO_FCAL_TRACK_EN
                        r_state <= ST_SETTLE;
                        r_go    <= 1'b1;
                        r_track <= 1'b1;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sw       = SW_W'(therm(int'(r_k)));
    assign k_out    = r_k;
    assign meas_cnt = r_meas_cnt;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_lc_dco_fcal.sv
`timescale 1ns/1ps
module tb_lc_dco_fcal;

    localparam int SW_W     = 8;
    localparam int CNT_W    = 12;
    localparam int KW       = 4;
    localparam int WIN      = 1024;
    localparam int SETTLE   = 64;
    localparam int ITER     = 4;
    localparam int DONE_LAT = 1 + ITER * (SETTLE + WIN + 1);
    localparam int NV       = 8;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic             manual_en = 1'b0;
    logic [KW-1:0]    manual_k = '0;
    logic [CNT_W-1:0] target_cnt = '0;
    logic             dco_edge = 1'b0;
    logic [SW_W-1:0]  sw;
    logic [KW-1:0]    k_out;
    logic [CNT_W-1:0] meas_cnt;
    logic             busy, done, err;

    logic             s_start = 1'b0;
    logic [SW_W-1:0]  s_sw;
    logic [KW-1:0]    s_k;
    logic [7:0]       s_meas;
    logic             s_busy, s_done, s_err;

    int n_chk  = 0;
    int n_pass = 0;

    // DCO plant: edges per window = m_base - m_slope*k + m_off, clamped to 0..WIN.
    int m_base = 900;
    int m_slope = 40;
    int m_off = 0;
    int acc = 0;

    typedef struct {
        int tgt;
        int base;
        int slope;
        int exp_k;
        int exp_err;
    } vec_t;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    lc_dco_fcal u_dut (
        .clk(clk), .resetn(resetn), .start(start), .manual_en(manual_en), .manual_k(manual_k),
        .target_cnt(target_cnt), .dco_edge(dco_edge), .sw(sw), .k_out(k_out), .meas_cnt(meas_cnt),
        .busy(busy), .done(done), .err(err)
    );

    lc_dco_fcal #(.CNT_W(8)) u_sat (
        .clk(clk), .resetn(resetn), .start(s_start), .manual_en(1'b0), .manual_k(4'd0),
        .target_cnt(8'd0), .dco_edge(1'b1), .sw(s_sw), .k_out(s_k), .meas_cnt(s_meas),
        .busy(s_busy), .done(s_done), .err(s_err)
    );

    function automatic int f_cnt(input int k);
        int v;
        v = m_base - m_slope * k + m_off;
        if (v < 0) v = 0;
        if (v > WIN) v = WIN;
        return v;
    endfunction

    // Expected result from the search definition: largest code meeting the target.
    function automatic void model(input int tgt, output int ek, output int eerr);
        ek = 0;
        eerr = 1;
        for (int k = 0; k <= SW_W; k++) begin
            if (f_cnt(k) >= tgt) begin
                ek = k;
                eerr = 0;
            end
        end
    endfunction

    // Phase accumulator gives exactly f_cnt(k) edges in any WIN consecutive cycles at fixed k.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            acc += f_cnt($countones(sw));
            if (acc >= WIN) begin
                acc -= WIN;
                dco_edge = 1'b1;
            end else begin
                dco_edge = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic run_search(input string tag, input int tgt, input int ek, input int eerr);
        int n;
        target_cnt = CNT_W'(tgt);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        check({tag, "_busy_hi"}, busy, 1);
        check({tag, "_done_clr"}, done, 0);
        while (!done && n < DONE_LAT + 200) begin
            start = (n == 2000);  // ignored: search in progress
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check({tag, "_done_lat"}, n, DONE_LAT);
        check({tag, "_k"}, k_out, ek);
        check({tag, "_sw"}, sw, (1 << ek) - 1);
        check({tag, "_err"}, err, eerr);
        check({tag, "_busy_lo"}, busy, 0);
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_done_hold"}, done, 1);
    endtask

    initial begin
        vecs[0] = '{tgt: 700,  base: 900, slope: 40, exp_k: 5, exp_err: 0};
        vecs[1] = '{tgt: 1000, base: 900, slope: 40, exp_k: 0, exp_err: 1};
        vecs[2] = '{tgt: 0,    base: 900, slope: 40, exp_k: 8, exp_err: 0};
        for (int i = 3; i < NV; i++) begin
            vecs[i].base  = int'($urandom_range(400, 1000));
            vecs[i].slope = int'($urandom_range(0, 70));
            vecs[i].tgt   = int'($urandom_range(100, 1040));
            m_base = vecs[i].base;
            m_slope = vecs[i].slope;
            m_off = 0;
            model(vecs[i].tgt, vecs[i].exp_k, vecs[i].exp_err);
        end

        // Reset state
        #23;
        check("rst_sw", sw, 0);
        check("rst_k", k_out, 0);
        check("rst_meas", meas_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            m_base = vecs[i].base;
            m_slope = vecs[i].slope;
            m_off = 0;
            run_search($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].exp_k, vecs[i].exp_err);
        end

        // Manual override during the second window
        m_base = 900; m_slope = 40; m_off = 0;
        target_cnt = CNT_W'(700);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (SETTLE + WIN + 1 + SETTLE + 200) @(posedge clk);
        #1;
        check("man_pre_busy", busy, 1);
        manual_en = 1'b1;
        manual_k = 4'd12;
        @(posedge clk);
        #1;
        check("man_busy", busy, 0);
        check("man_k", k_out, 8);
        check("man_sw", sw, 8'hFF);
        check("man_done", done, 0);
        check("man_meas_hold", meas_cnt, 740);
        manual_en = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("man_k_hold", k_out, 8);
        check("man_idle", busy, 0);
        run_search("man_rerun", 700, 5, 0);

        // Asynchronous reset mid-SETTLE
        target_cnt = CNT_W'(700);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        check("ares_pre_k", k_out, 4);
        check("ares_pre_busy", busy, 1);
        resetn = 1'b0;
        #1;
        check("ares_sw", sw, 0);
        check("ares_k", k_out, 0);
        check("ares_busy", busy, 0);
        check("ares_done", done, 0);
        check("ares_meas", meas_cnt, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        run_search("ares_rerun", 700, 5, 0);

        // Saturation: an edge every cycle into an 8-bit counter
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        repeat (SETTLE + WIN + 20) @(posedge clk);
        #1;
        check("sat_cnt", s_meas, 255);
        check("sat_busy", s_busy, 1);

`ifdef LC_DCO_FCAL_TRACK_EN
        begin : trk_blk
            int n;
            int moved;
            m_base = 900; m_slope = 40; m_off = 0;
            run_search("trk_lock", 700, 5, 0);
            m_off = 80;
            n = 0;
            while (k_out != 4'd6 && n < 3000) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("trk_k6", k_out, 6);
            n = 0;
            while (k_out == 4'd6 && n < 1500) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("trk_k7", k_out, 7);
            check("trk_one_window", (n >= WIN && n <= WIN + SETTLE + 4), 1);
            m_off = 81;
            moved = 0;
            repeat (3 * (WIN + SETTLE + 2)) begin
                @(posedge clk);
                #1;
                if (k_out != 4'd7) moved++;
            end
            check("trk_hyst_hold", moved, 0);
            check("trk_done", done, 1);
            check("trk_busy", busy, 0);
            check("trk_err", err, 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
